fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (legal range >= 2).
REQ-002 SHALL provide port clk  input  1  rising-edge clock shared with the upstream synchronous FIFO.
REQ-003 SHALL provide port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 SHALL provide port enable  input  1  permits new byte fetches when high.
REQ-005 SHALL provide port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL provide port fifo_dout  input  8  upstream FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 SHALL provide port fifo_rd_en  output  1  registered read strobe to the upstream FIFO.
REQ-008 SHALL provide port tx  output  1  registered UART 8N1 serial line, idle high.
REQ-009 SHALL provide port busy  output  1  high while a fetch or frame is in progress.
REQ-010 SHALL provide port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-012 SHALL move IDLE->FETCH only when enable=1 and fifo_empty=0 are sampled in IDLE; otherwise SHALL remain in IDLE.
REQ-013 SHALL assert fifo_rd_en high for exactly the one cycle spent in FETCH and low in every other state.
REQ-014 SHALL move FETCH->LOAD unconditionally, then capture fifo_dout into an 8-bit shift register at the end of LOAD and move LOAD->START.
REQ-015 SHALL drive tx=1 in IDLE, FETCH, LOAD and STOP, tx=0 in START, and tx=current shift-register LSB in DATA.
REQ-016 SHALL hold START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT) that clears on every bit boundary.
REQ-017 SHALL transmit data LSB first: 8 DATA bits, counted by a 3-bit index, shifting right at each bit boundary.
REQ-018 SHALL move DATA->STOP after bit index 7 completes, and STOP->IDLE after the stop bit completes.
REQ-019 SHALL pulse tx_done high for exactly the last cycle of STOP.
REQ-020 SHALL drive busy=0 in IDLE and busy=1 in all other states.
REQ-021 SHALL leave a back-to-back inter-frame gap of exactly 3 tx-high cycles (IDLE, FETCH, LOAD) after the stop bit.
REQ-022 SHALL complete the current frame normally when enable deasserts mid-frame, and SHALL not fetch again while enable=0.
REQ-023 SHALL ignore fifo_empty and fifo_dout in every state except the sampling points in IDLE and LOAD.
REQ-024 SHALL give a frame latency of 3 cycles from the IDLE decision cycle to the first start-bit cycle, and SHALL make a frame 10*CLKS_PER_BIT cycles long.

Reset
REQ-025 SHALL, on reset=1 at a rising clk edge, enter IDLE, clear the baud counter, bit index and shift register, and drive tx=1, busy=0, fifo_rd_en=0 and tx_done=0 from the next cycle.
REQ-026 SHALL, on reset mid-frame, abort the frame, discard the byte, and leave FIFO state untouched by this block.
REQ-027 SHALL, when reset and a fetch condition coincide, give reset priority: no fifo_rd_en is issued.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL cover reset held 3 cycles with fifo_empty=0 and enable=1 -> tx=1, busy=0, fifo_rd_en=0 throughout, then fetch starts on the first cycle after release.
REQ-029 SHALL cover a FIFO holding 0xA5 -> one fifo_rd_en pulse, then tx = 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles, and tx_done pulsing on cycle 40 of the frame.
REQ-030 SHALL cover a FIFO holding 0x00 then 0xFF -> two rd_en pulses, frames 0,00000000,1 and 0,11111111,1, separated by exactly 3 high cycles after stop.
REQ-031 SHALL cover fifo_empty=1 for 100 cycles with enable=1 -> fifo_rd_en never asserted, tx=1, busy=0.
REQ-032 SHALL cover enable dropped during DATA bit 2 with the FIFO non-empty -> the frame finishes with tx_done pulsing once, then no rd_en while enable=0.
REQ-033 SHALL cover reset asserted during DATA bit 5 -> tx=1 and busy=0 on the next cycle, with no tx_done pulse.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART 8N1 transmitter that pulls bytes from an upstream synchronous FIFO
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          tx_next;
  logic          bit_done;

  assign bit_done = (baud == BAUD_LAST);
  assign busy     = (state != IDLE);
  assign tx_done  = (state == STOP) && bit_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_next;
      baud       <= baud_next;
      bit_idx    <= bit_next;
      shift      <= shift_next;
      tx         <= tx_next;
      fifo_rd_en <= (state_next == FETCH);
    end
  end

  // FIFO data is only valid in LOAD, one cycle after the FETCH read strobe.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (enable && !fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        shift_next = fifo_dout;
        baud_next  = '0;
        state_next = START;
      end
      START: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // The line is registered from the next-state view so it tracks the state register exactly.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule
